alu_exec_ctrl: RTL

- Multi-cycle execute-stage sequencer on the control-unit side of the datapath ALU.
- Accepts one decoded operation with its operands and drives the combinational ALU inputs: operands, 5-bit op code and shift amount.
- Waits the required settle/latency cycles, then captures aluOut and zero into registered outputs.
- Resolves branch conditions, blocks divide/remainder by zero, and handshakes with the control unit via start/ready/done.

---
 rtl/alu_exec_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: multi-cycle execute-stage sequencer that drives the datapath
// ALU, waits out its latency, captures result/zero and resolves branches.
// Optional: define ALU_OVF_DETECT_EN to build signed add/sub overflow detection.
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   start / ready / done    request, idle indication, one-cycle completion
//   op_sel, use_imm,        decoded operation, operand select, branch kind
//   br_cond
//   rs_data, rt_data, imm,  operands and shift amount
//   shamt_in
//   alu_data1, alu_data2,   registered ALU inputs
//   alu_op, alu_shamt
//   alu_out, alu_zero       ALU results
//   result, zero_flag,      captured results, valid from done onwards
//   branch_taken, div_err,
//   overflow
module alu_exec_ctrl #(
    parameter int MULDIV_WAIT = 4,
    parameter int DATA_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              ready,
    input  logic [4:0]        op_sel,
    input  logic              use_imm,
    input  logic [1:0]        br_cond,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    input  logic [4:0]        shamt_in,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    output logic [4:0]        alu_op,
    output logic [4:0]        alu_shamt,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic [DATA_W-1:0] result,
    output logic              zero_flag,
    output logic              branch_taken,
    output logic              div_err,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;

    localparam logic [4:0] OP_MUL = 5'b01100;
    localparam logic [4:0] OP_DIV = 5'b01101;
    localparam logic [4:0] OP_REM = 5'b01110;

    state_t            state;
    logic [1:0]        br_q;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] op2_sel;
    logic              is_muldiv;
    logic              div_zero;

    always_comb begin
        op2_sel   = use_imm ? imm : rt_data;
        is_muldiv = (op_sel == OP_MUL) || (op_sel == OP_DIV) ||
                    (op_sel == OP_REM);
        div_zero  = ((op_sel == OP_DIV) || (op_sel == OP_REM)) &&
                    (op2_sel == '0);
    end

`ifdef ALU_OVF_DETECT_EN
    logic ovf_q;
    logic ovf_next;
    logic sa, sb, sr;

    // Signed overflow judged from the sign bits of the held operands and
    // the ALU result; sub overflows when operands differ in sign and the
    // result sign departs from the minuend.
    always_comb begin
        sa       = alu_data1[DATA_W-1];
        sb       = alu_data2[DATA_W-1];
        sr       = alu_out[DATA_W-1];
        ovf_next = 1'b0;
        case (alu_op)
            5'b00001: ovf_next = (sa == sb) && (sr != sa);
            5'b00010: ovf_next = (sa != sb) && (sr != sa);
            default:  ovf_next = 1'b0;
        endcase
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ready        <= 1'b1;
            done         <= 1'b0;
            br_q         <= '0;
            cnt          <= '0;
            alu_data1    <= '0;
            alu_data2    <= '0;
            alu_op       <= '0;
            alu_shamt    <= '0;
            result       <= '0;
            zero_flag    <= 1'b0;
            branch_taken <= 1'b0;
            div_err      <= 1'b0;
`ifdef ALU_OVF_DETECT_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        alu_data1 <= rs_data;
                        alu_data2 <= op2_sel;
                        alu_op    <= op_sel;
                        alu_shamt <= shamt_in;
                        br_q      <= br_cond;
                        ready     <= 1'b0;
                        cnt       <= is_muldiv ? 4'(MULDIV_WAIT) : 4'd0;
                        if (div_zero) begin
                            // Skip the ALU entirely; flag the error now.
                            result       <= '1;
                            div_err      <= 1'b1;
                            zero_flag    <= 1'b0;
                            branch_taken <= 1'b0;
`ifdef ALU_OVF_DETECT_EN
                            ovf_q        <= 1'b0;
`endif
                            done         <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt == 4'd0) state <= CAPTURE;
                    else             cnt   <= cnt - 4'd1;
                end
                CAPTURE: begin
                    result       <= alu_out;
                    zero_flag    <= alu_zero;
                    div_err      <= 1'b0;
                    branch_taken <= ((br_q == 2'b01) &&  alu_zero) ||
                                    ((br_q == 2'b10) && !alu_zero);
`ifdef ALU_OVF_DETECT_EN
                    ovf_q        <= ovf_next;
`endif
                    done         <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
